// File: rtl/ssd_display_sched_if.sv
// ssd_display_sched_if: requester inputs and display outputs of the SSD display scheduler
interface ssd_display_sched_if;
  logic [6:0]  score_l;
  logic [6:0]  score_r;
  logic        score_upd;
  logic        cd_req;
  logic [3:0]  cd_val;
  logic        blink_en;
  logic        tick;
  logic [15:0] nums;
  logic        busy;
  modport master (
    output score_l, score_r, score_upd, cd_req, cd_val, blink_en, tick,
    input  nums, busy
  );
  modport slave (
    input  score_l, score_r, score_upd, cd_req, cd_val, blink_en, tick,
    output nums, busy
  );
endinterface

// File: rtl/ssd_display_sched.sv
// ssd_display_sched: arbitrates the four-digit display between score, countdown and blink overlay
module ssd_display_sched #(
  parameter logic [3:0] DASH      = 4'hA,
  parameter int         MAX_SCORE = 99
) (
  input logic clk,
  input logic rst_n,
  ssd_display_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CONV_L, CONV_R, COMMIT} state_t;
  localparam logic [6:0] MAX = 7'(MAX_SCORE);
  state_t      state_q, state_d;
  logic [6:0]  wl_q, wl_d, wr_q, wr_d;
  logic [3:0]  tens_l_q, tens_l_d, tens_r_q, tens_r_d;
  logic [15:0] score_disp_q, score_disp_d;
  logic        pending_q, pending_d;
  logic        cd_active_q, cd_active_d;
  logic [3:0]  cd_digit_q, cd_digit_d;
  logic        blink_ph_q, blink_ph_d;
  // state registers; reset clears the display immediately and drops any conversion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wl_q         <= '0;
      wr_q         <= '0;
      tens_l_q     <= '0;
      tens_r_q     <= '0;
      score_disp_q <= '0;
      pending_q    <= 1'b0;
      cd_active_q  <= 1'b0;
      cd_digit_q   <= '0;
      blink_ph_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wl_q         <= wl_d;
      wr_q         <= wr_d;
      tens_l_q     <= tens_l_d;
      tens_r_q     <= tens_r_d;
      score_disp_q <= score_disp_d;
      pending_q    <= pending_d;
      cd_active_q  <= cd_active_d;
      cd_digit_q   <= cd_digit_d;
      blink_ph_q   <= blink_ph_d;
    end
  end
  // score conversion: repeated subtract-10 per side, then one atomic commit
  always_comb begin
    state_d      = state_q;
    wl_d         = wl_q;
    wr_d         = wr_q;
    tens_l_d     = tens_l_q;
    tens_r_d     = tens_r_q;
    score_disp_d = score_disp_q;
    pending_d    = pending_q | (bus.score_upd & (state_q != IDLE));
    case (state_q)
      IDLE: if (bus.score_upd | pending_q) begin
        wl_d      = (bus.score_l > MAX) ? MAX : bus.score_l;
        wr_d      = (bus.score_r > MAX) ? MAX : bus.score_r;
        tens_l_d  = '0;
        tens_r_d  = '0;
        pending_d = 1'b0;
        state_d   = CONV_L;
      end
      CONV_L: if (wl_q >= 7'd10) begin
        wl_d     = wl_q - 7'd10;
        tens_l_d = tens_l_q + 4'd1;
      end else state_d = CONV_R;
      CONV_R: if (wr_q >= 7'd10) begin
        wr_d     = wr_q - 7'd10;
        tens_r_d = tens_r_q + 4'd1;
      end else state_d = COMMIT;
      default: begin
        score_disp_d = {tens_l_q, wl_q[3:0], tens_r_q, wr_q[3:0]};
        state_d      = IDLE;
      end
    endcase
  end
  // countdown capture and blink phase, refreshed every cycle
  always_comb begin
    cd_active_d = bus.cd_req;
    cd_digit_d  = (bus.cd_val > 4'd9) ? 4'd9 : bus.cd_val;
    blink_ph_d  = !bus.blink_en ? 1'b0 : bus.tick ? ~blink_ph_q : blink_ph_q;
  end
  assign bus.nums = blink_ph_q  ? {4{DASH}} :
                    cd_active_q ? {DASH, DASH, 4'h0, cd_digit_q} : score_disp_q;
  assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_ssd_display_sched.sv
// tb_ssd_display_sched: directed checks of conversion latency, pending, countdown, blink and reset
module tb_ssd_display_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  ssd_display_sched_if bus();
  ssd_display_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_conv(input logic [6:0] l, input logic [6:0] r, input int ncyc,
                          input logic [15:0] exp, input logic [15:0] prev);
    int n;
    bus.score_l = l;
    bus.score_r = r;
    bus.score_upd = 1'b1;
    step();
    bus.score_upd = 1'b0;
    chk("busy_rise", 16'(bus.busy), 16'd1);
    n = 0;
    while (bus.busy && n < 40) begin
      if (n == ncyc - 1) chk("pre_commit", bus.nums, prev);
      step();
      n++;
    end
    chk("busy_cycles", 16'(n), 16'(ncyc));
    chk("score", bus.nums, exp);
  endtask
  initial begin
    bus.score_l = '0;
    bus.score_r = '0;
    bus.score_upd = 1'b0;
    bus.cd_req = 1'b0;
    bus.cd_val = '0;
    bus.blink_en = 1'b0;
    bus.tick = 1'b0;
    #12;
    chk("rst_nums", bus.nums, 16'h0000);
    chk("rst_busy", 16'(bus.busy), 16'd0);
    rst_n = 1'b1;
    step();
    run_conv(7'd37, 7'd5, 6, 16'h3705, 16'h0000);
    run_conv(7'd120, 7'd99, 21, 16'h9999, 16'h3705);
    bus.score_l = 7'd50;
    bus.score_r = 7'd50;
    bus.score_upd = 1'b1;
    step();
    for (int k = 1; k <= 25; k++) begin
      bus.score_upd = (k == 3 || k == 5 || k == 7);
      if (k == 7) begin
        bus.score_l = 7'd1;
        bus.score_r = 7'd2;
      end
      step();
      bus.score_upd = 1'b0;
      if (k == 12) chk("pend_pre", bus.nums, 16'h9999);
      if (k == 13) chk("pend_first", bus.nums, 16'h5050);
      if (k == 14) chk("pend_busy", 16'(bus.busy), 16'd1);
      if (k == 17) chk("pend_second", bus.nums, 16'h0102);
      if (k == 17) chk("pend_idle", 16'(bus.busy), 16'd0);
      if (k == 25) chk("pend_once", {15'd0, bus.busy}, 16'd0);
    end
    chk("pend_final", bus.nums, 16'h0102);
    bus.cd_req = 1'b1;
    bus.cd_val = 4'd12;
    #1;
    chk("cd_no_comb", bus.nums, 16'h0102);
    step();
    chk("cd_sat", bus.nums, 16'hAA09);
    bus.cd_val = 4'd7;
    step();
    chk("cd_val", bus.nums, 16'hAA07);
    bus.cd_req = 1'b0;
    step();
    chk("cd_drop", bus.nums, 16'h0102);
    bus.blink_en = 1'b1;
    step();
    chk("blink_notick", bus.nums, 16'h0102);
    bus.tick = 1'b1;
    step();
    chk("blink_on", bus.nums, 16'hAAAA);
    step();
    chk("blink_off", bus.nums, 16'h0102);
    step();
    bus.tick = 1'b0;
    bus.cd_req = 1'b1;
    bus.cd_val = 4'd3;
    step();
    chk("blink_prio", bus.nums, 16'hAAAA);
    bus.cd_req = 1'b0;
    bus.blink_en = 1'b0;
    step();
    chk("blink_clear", bus.nums, 16'h0102);
    bus.score_l = 7'd4;
    bus.score_r = 7'd3;
    bus.score_upd = 1'b1;
    bus.cd_req = 1'b1;
    bus.cd_val = 4'd5;
    step();
    bus.score_upd = 1'b0;
    chk("sim_cd", bus.nums, 16'hAA05);
    chk("sim_busy", 16'(bus.busy), 16'd1);
    step();
    step();
    step();
    chk("sim_hold", bus.nums, 16'hAA05);
    bus.cd_req = 1'b0;
    step();
    chk("sim_score", bus.nums, 16'h0403);
    bus.score_l = 7'd99;
    bus.score_r = 7'd99;
    bus.score_upd = 1'b1;
    step();
    bus.score_upd = 1'b0;
    for (int k = 0; k < 12; k++) step();
    chk("rst_mid_busy", 16'(bus.busy), 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_nums", bus.nums, 16'h0000);
    chk("rst_async_busy", 16'(bus.busy), 16'd0);
    #4;
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) step();
    chk("rst_no_commit", bus.nums, 16'h0000);
    chk("rst_stay_idle", 16'(bus.busy), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
